// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned WORD_BYTES = 2;

    typedef enum logic [3:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CSUM_HI,
        CSUM_LO,
        DONE,
        ERR
    } state_e;

    // States that wait for the high byte of a word.
    function automatic logic is_hi_state(input state_e s);
        return (s == HDR_HI) || (s == DATA_HI) || (s == CSUM_HI);
    endfunction

    // States that wait for the low byte of a word.
    function automatic logic is_lo_state(input state_e s);
        return (s == HDR_LO) || (s == DATA_LO) || (s == CSUM_LO);
    endfunction

    // States in which the loader takes bytes from the source.
    function automatic logic accepts_bytes(input state_e s);
        return is_hi_state(s) || is_lo_state(s);
    endfunction

endpackage

// File: rtl/imem_loader_byte_pair_packer.sv
// Packs two consecutive stream bytes (high first) into one 16-bit word.
module imem_loader_byte_pair_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hi_fire_i,
    input  logic              lo_fire_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    logic [BYTE_W-1:0] hi_q;

    // Hold the high byte until its partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
        end else if (hi_fire_i) begin
            hi_q <= byte_i;
        end
    end

    // The word is complete on the low-byte handshake itself.
    assign word_c       = {hi_q, byte_i};
    assign word_valid_c = lo_fire_i;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a counted, checksummed image and writes it to instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              byte_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   n_q, n_d;
    logic [WORD_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]   xor_q, xor_d;
    logic                ready_q;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                hold_q, done_q, err_q;

    logic                fire_c, hi_fire_c, lo_fire_c;
    logic [WORD_W-1:0]   word_c;
    logic                word_valid_c;

    assign fire_c    = byte_valid && ready_q;
    assign hi_fire_c = fire_c && is_hi_state(state_q);
    assign lo_fire_c = fire_c && is_lo_state(state_q);

    imem_loader_byte_pair_packer u_packer (
        .clk          (clk),
        .rst_n        (rst),
        .hi_fire_i    (hi_fire_c),
        .lo_fire_i    (lo_fire_c),
        .byte_i       (byte_data),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    // Next-state, counters, checksum and write-port updates.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        xor_d   = xor_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            HDR_HI: begin
                if (hi_fire_c) state_d = HDR_LO;
            end
            HDR_LO: begin
                if (word_valid_c) begin
                    n_d = word_c;
                    if (word_c == WORD_W'(0)) begin
                        state_d = CSUM_HI;
                    end else if (32'(word_c) > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (hi_fire_c) state_d = DATA_LO;
            end
            DATA_LO: begin
                if (word_valid_c) begin
                    state_d = WRITE;
                    wr_d    = 1'b1;
                    addr_d  = BASE_ADDR + ADDR_W'(32'(idx_q) * WORD_BYTES);
                    data_d  = word_c;
                    xor_d   = xor_q ^ word_c;
                    idx_d   = idx_q + WORD_W'(1);
                end
            end
            WRITE: begin
                // idx_q already counts the word being written this cycle.
                state_d = (idx_q < n_q) ? DATA_HI : CSUM_HI;
            end
            CSUM_HI: begin
                if (hi_fire_c) state_d = CSUM_LO;
            end
            CSUM_LO: begin
                if (word_valid_c) state_d = (word_c == xor_q) ? DONE : ERR;
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // State and registered outputs; status flags follow the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HDR_HI;
            n_q     <= '0;
            idx_q   <= '0;
            xor_q   <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            ready_q <= accepts_bytes(state_d);
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= (state_d != DONE);
            done_q  <= (state_d == DONE);
            err_q   <= (state_d == ERR);
        end
    end

    assign byte_ready = ready_q;
    assign mem_wr     = wr_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-level reference model plus directed and random images.
module tb_imem_loader;

    localparam int unsigned MAXW = 1024;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic        byte_ready;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W    (16),
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: works on the accepted byte sequence ----------------
    logic [7:0]  acc[$];
    logic [15:0] m_words[$];
    int          m_n;
    int          m_status;     // 0 loading, 1 done, 2 error
    bit          m_ready;
    bit          m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_data;

    task automatic model_step();
        int          k;
        int          idx;
        logic [15:0] w;
        logic [15:0] cs;
        bit          hs;
        if (!rst) begin
            acc.delete();
            m_words.delete();
            m_n      = 0;
            m_status = 0;
            m_ready  = 0;
            m_wr     = 0;
            m_addr   = BASE;
            m_data   = 16'h0000;
            return;
        end
        hs   = byte_valid && m_ready;
        m_wr = 0;
        if (hs) begin
            acc.push_back(byte_data);
            k = acc.size();
            if (k == 2) begin
                m_n = int'({acc[0], acc[1]});
                if (m_n > int'(MAXW)) m_status = 2;
            end else if (k > 2 && (k % 2) == 0) begin
                w = {acc[k-2], acc[k-1]};
                if (k <= 2 * m_n + 2) begin
                    idx    = (k - 4) / 2;
                    m_wr   = 1;
                    m_addr = 16'(int'(BASE) + 2 * idx);
                    m_data = w;
                    m_words.push_back(w);
                end else begin
                    cs = 16'h0000;
                    foreach (m_words[j]) cs = cs ^ m_words[j];
                    m_status = (w == cs) ? 1 : 2;
                end
            end
        end
        m_ready = (m_status == 0) && !m_wr;
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    // ---------------- per-cycle compare and write monitor ----------------
    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t wr_log[$];

    initial begin
        forever begin
            @(negedge clk);
            chk("byte_ready", byte_ready, m_ready);
            chk("mem_wr",     mem_wr,     m_wr);
            chk("mem_addr",   mem_addr,   m_addr);
            chk("mem_data",   mem_data,   m_data);
            chk("cpu_hold",   cpu_hold,   (m_status != 1));
            chk("done",       done,       (m_status == 1));
            chk("err",        err,        (m_status == 2));
            if (mem_wr === 1'b1) wr_log.push_back('{a: mem_addr, d: mem_data});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] img[$];

    task automatic push_word(input logic [15:0] w);
        img.push_back(w[15:8]);
        img.push_back(w[7:0]);
    endtask

    task automatic run_image(input int pct, input int extra);
        int i;
        int guard;
        i     = 0;
        guard = 0;
        while (i < img.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
            byte_valid = ($urandom_range(99) < pct);
            byte_data  = img[i];
            if (byte_valid && byte_ready) i++;
        end
        repeat (extra) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'($urandom_range(255));
        end
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stream_consumed", 32'(i), 32'(img.size()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_log.delete();
        img.delete();
    endtask

    task automatic chk_wr(input int n, input logic [15:0] a, input logic [15:0] d);
        checks++;
        if (wr_log.size() <= n) begin
            errors++;
            $display("FAIL wr_log_entry%0d: got %0d writes expected more", n, wr_log.size());
        end else begin
            chk("wr_addr", wr_log[n].a, a);
            chk("wr_data", wr_log[n].d, d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        bit          bad;
        logic [15:0] w;
        logic [15:0] cs;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", byte_ready, 0);
        chk("rst_hold",  cpu_hold,   1);
        chk("rst_addr",  mem_addr,   32'(BASE));
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", byte_ready, 1);

        // Good N=2 image at full rate.
        push_word(16'd2); push_word(16'hA123); push_word(16'h4567); push_word(16'hE444);
        run_image(100, 0);
        chk("t1_done", done, 1); chk("t1_hold", cpu_hold, 0); chk("t1_err", err, 0);
        chk("t1_model_status", 32'(m_status), 1);
        chk("t1_nwr", 32'(wr_log.size()), 2);
        chk_wr(0, 16'h0000, 16'hA123);
        chk_wr(1, 16'h0002, 16'h4567);

        // Bad checksum; later bytes must be refused.
        do_reset();
        push_word(16'd2); push_word(16'hA123); push_word(16'h4567); push_word(16'hE445);
        run_image(100, 6);
        chk("t2_err", err, 1); chk("t2_done", done, 0); chk("t2_hold", cpu_hold, 1);
        chk("t2_ready", byte_ready, 0);
        chk("t2_nwr", 32'(wr_log.size()), 2);

        // Oversized header.
        do_reset();
        push_word(16'(MAXW + 1));
        run_image(100, 8);
        chk("t3_err", err, 1); chk("t3_nwr", 32'(wr_log.size()), 0);

        // Empty image.
        do_reset();
        push_word(16'd0); push_word(16'h0000);
        run_image(100, 0);
        chk("t4_done", done, 1); chk("t4_nwr", 32'(wr_log.size()), 0);

        // N=2 image with a 50% source.
        do_reset();
        push_word(16'd2); push_word(16'hA123); push_word(16'h4567); push_word(16'hE444);
        run_image(50, 0);
        chk("t5_done", done, 1);
        chk_wr(0, 16'h0000, 16'hA123);
        chk_wr(1, 16'h0002, 16'h4567);

        // Reset after the first payload word, then reload.
        do_reset();
        push_word(16'd2); push_word(16'hA123);
        run_image(100, 0);
        chk("t6_nwr_before", 32'(wr_log.size()), 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_ready", byte_ready, 0);
        chk("t6_async_wr",    mem_wr,     0);
        chk("t6_async_addr",  mem_addr,   32'(BASE));
        chk("t6_async_data",  mem_data,   0);
        chk("t6_async_hold",  cpu_hold,   1);
        chk("t6_async_done",  done,       0);
        chk("t6_async_err",   err,        0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wr_log.delete();
        img.delete();
        push_word(16'd1); push_word(16'hBEEF); push_word(16'hBEEF);
        run_image(100, 0);
        chk("t6_done", done, 1);
        chk("t6_nwr", 32'(wr_log.size()), 1);
        chk_wr(0, 16'h0000, 16'hBEEF);

        // Random images, some with corrupted checksums.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            n   = $urandom_range(6, 1);
            bad = 1'($urandom_range(1));
            cs  = 16'h0000;
            push_word(16'(n));
            for (int j = 0; j < n; j++) begin
                w  = 16'($urandom);
                cs = cs ^ w;
                push_word(w);
            end
            if (bad) cs = cs ^ 16'(1 << $urandom_range(15));
            push_word(cs);
            run_image(int'($urandom_range(90, 30)), 3);
            chk("rnd_done", done, !bad);
            chk("rnd_err",  err,  bad);
            chk("rnd_nwr",  32'(wr_log.size()), 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory. After reset it receives a program image as a byte stream over a valid/ready handshake and packs the bytes into 16-bit words. It writes each word into instruction memory through a write port, verifies an XOR checksum, and holds the CPU in reset until the image has loaded cleanly. It sits between the off-chip byte source and the instruction memory, and its output gates the CPU reset.

## Interface
Parameters:
- ADDR_W, 16, width of mem_addr (byte address).
- BASE_ADDR, 16'h0000, byte address of the first payload word.
- MAX_WORDS, 1024, largest accepted payload word count.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_wr  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  ADDR_W  byte address of the word being written.
- mem_data  out  16  word being written.
- cpu_hold  out  1  high keeps the CPU in reset.
- done  out  1  image loaded and checksum matched (sticky).
- err  out  1  load failed (sticky).

## Operation
- Stream format, all words big-endian (high byte first):
  - header word N: payload word count.
  - N payload words.
  - checksum word: XOR of all N payload words, 16'h0000 when N=0.
- A byte transfers only when byte_valid and byte_ready are both high in the same cycle.
- FSM states and transitions:
  - HDR_HI -> HDR_LO.
  - HDR_LO -> DATA_HI if 0<N≤MAX_WORDS; -> CSUM_HI if N=0; -> ERR if N>MAX_WORDS.
  - DATA_HI -> DATA_LO.
  - DATA_LO -> WRITE.
  - WRITE -> DATA_HI while words remain; -> CSUM_HI after word N.
  - CSUM_HI -> CSUM_LO.
  - CSUM_LO -> DONE on match; -> ERR on mismatch.
  - DONE and ERR are terminal until reset.
- Every state change out of a *_HI or *_LO state requires a completed byte transfer.
- Write address: mem_addr = BASE_ADDR + 2·idx, where idx is the 0-based payload index. The address steps by 2 because the PC advances by 2 bytes per instruction. Arithmetic is modulo 2^ADDR_W, so the address wraps silently.
- The running XOR accumulates each payload word as it is written. It resets to 0 on reset.
- Output levels:
  - byte_ready is high in HDR_*, DATA_*, CSUM_*; low in WRITE, DONE, ERR.
  - cpu_hold is high in every state except DONE.
  - done is high only in DONE; err is high only in ERR.
  - Bytes offered in DONE or ERR are never accepted.
- Reset mid-load: the FSM returns to HDR_HI and the word index and XOR clear. Memory contents already written are not cleared.

## Timing
- Reset values: byte_ready=0 while rst is low. byte_ready=1 from the first clk edge after rst releases, with state HDR_HI. mem_wr=0, mem_addr=BASE_ADDR, mem_data=0, cpu_hold=1, done=0, err=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from byte_valid or byte_data to any output.
- Word write latency: mem_wr pulses for exactly 1 cycle, in the cycle after the low-byte handshake. mem_addr and mem_data are stable during that cycle and hold afterwards.
- Throughput: 3 cycles per payload word at full source rate (2 byte cycles + 1 WRITE cycle).
- done/err/cpu_hold update in the cycle after the final checksum byte handshake.
- byte_valid may stay high across a byte_ready-low cycle; the byte is not consumed and is presented again.

## Structure
- Package imem_loader_pkg:
  - state enum: HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, CSUM_HI, CSUM_LO, DONE, ERR.
  - constant WORD_BYTES = 2.
- One natural sub-module, byte_pair_packer: latches the high byte and emits the 16-bit word on the low-byte handshake. It is reused for header, payload and checksum.
- The index counter, XOR accumulator and FSM live in the top level.

## Test plan
- Load N=2, payload 16'hA123, 16'h4567, checksum 16'hE444, BASE_ADDR=0:
  - writes (0x0000, A123) and (0x0002, 4567).
  - done=1 and cpu_hold=0 one cycle after the last byte; err=0.
- Same image with checksum 16'hE445:
  - both words written.
  - err=1, done=0, cpu_hold stays 1.
  - further bytes are not accepted.
- Header N=MAX_WORDS+1:
  - err=1 after the header low byte; no mem_wr ever.
- N=0 with checksum 16'h0000:
  - done=1 with no writes.
- Source toggles byte_valid randomly (50%) on the N=2 image:
  - identical writes and result.
  - no byte is accepted during WRITE.
- Assert rst low after the first payload word is written, then reload a fresh N=1 image (16'hBEEF, checksum BEEF):
  - all outputs return to reset values asynchronously.
  - the reload writes (0x0000, BEEF), then done=1.
